// File: rtl/mult_div_pkg.sv
// Shared types and constants for the HI/LO mult/div sequencer.
// The TMO state exists only when MULT_DIV_TIMEOUT_EN is defined.
package mult_div_pkg;

    localparam int   MD_TIMEOUT = 64;
    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        MD_IDLE   = 3'd0,
        MD_LAUNCH = 3'd1,
        MD_WAIT   = 3'd2,
        MD_COMMIT = 3'd3,
        MD_EXC    = 3'd4
`ifdef MULT_DIV_TIMEOUT_EN
        ,
        MD_TMO    = 3'd5
`endif
    } md_state_t;

endpackage

// File: rtl/md_wait_counter.sv
// Clearable, saturating up-counter that flags when it holds LIMIT-1.
// Only instantiated when MULT_DIV_TIMEOUT_EN is defined.
module md_wait_counter
    import mult_div_pkg::*;
#(
    parameter int LIMIT = MD_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    assign terminal = (count == CW'(LIMIT - 1));

    // Holds at LIMIT-1 so terminal stays asserted until cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequencer owning the HI/LO write path for the multiplier and divider.
// Optional WAIT timeout enabled by defining MULT_DIV_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a request
// LAUNCH | pulse the selected engine start, or divert to EXC on div-by-zero
// WAIT   | wait for the selected engine's ready, capture its result
// COMMIT | write captured result to HI/LO, pulse done
// EXC    | divide-by-zero exception pulse with done
// TMO    | engine never answered, timeout pulse with done
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = MD_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_b,
    output logic             req_ready,
    input  logic             flush,
    output logic             mult_start,
    output logic             div_start,
    input  logic             mult_ready,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    output logic [WIDTH-1:0] hi_in,
    output logic [WIDTH-1:0] lo_in,
    output logic             hi_wr,
    output logic             lo_wr,
    output logic             done,
    output logic             div_zero_exc,
    output logic             timeout_err,
    output logic             busy
);

    if (TIMEOUT < 2 || TIMEOUT > 1024) begin : g_bad_timeout
        $error("mult_div_ctrl: TIMEOUT must be within 2..1024");
    end

    md_state_t        state, state_nxt;
    logic             op_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] res_hi_q;
    logic [WIDTH-1:0] res_lo_q;
    logic             sel_ready;
    logic             wait_term;

    assign sel_ready = (op_q == MD_OP_DIV) ? div_ready : mult_ready;

`ifdef MULT_DIV_TIMEOUT_EN
    md_wait_counter #(
        .LIMIT (TIMEOUT)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (state == MD_LAUNCH),
        .en       (state == MD_WAIT),
        .terminal (wait_term)
    );
`else
    assign wait_term = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MD_IDLE:   if (req_valid) state_nxt = MD_LAUNCH;
            MD_LAUNCH: state_nxt = (op_q == MD_OP_DIV && b_zero_q) ? MD_EXC : MD_WAIT;
            MD_WAIT: begin
                if (sel_ready) begin
                    state_nxt = MD_COMMIT;
`ifdef MULT_DIV_TIMEOUT_EN
                end else if (wait_term) begin
                    state_nxt = MD_TMO;
`endif
                end
            end
            default:   state_nxt = MD_IDLE;
        endcase
        if (flush) state_nxt = MD_IDLE;
    end

    // Flush is the only input allowed to gate outputs: it must kill this cycle's pulse.
    always_comb begin
        req_ready    = (state == MD_IDLE);
        busy         = (state != MD_IDLE);
        mult_start   = 1'b0;
        div_start    = 1'b0;
        hi_wr        = 1'b0;
        lo_wr        = 1'b0;
        done         = 1'b0;
        div_zero_exc = 1'b0;
        timeout_err  = 1'b0;
        if (!flush) begin
            unique case (state)
                MD_LAUNCH: begin
                    if (op_q == MD_OP_MULT) mult_start = 1'b1;
                    else if (!b_zero_q)     div_start  = 1'b1;
                end
                MD_COMMIT: begin
                    hi_wr = 1'b1;
                    lo_wr = 1'b1;
                    done  = 1'b1;
                end
                MD_EXC: begin
                    div_zero_exc = 1'b1;
                    done         = 1'b1;
                end
`ifdef MULT_DIV_TIMEOUT_EN
                MD_TMO: begin
                    timeout_err = 1'b1;
                    done        = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= MD_OP_MULT;
            b_zero_q <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            if (state == MD_IDLE && req_valid) begin
                op_q     <= req_op;
                b_zero_q <= (req_b == '0);
            end
            if (state == MD_WAIT && sel_ready) begin
                res_hi_q <= (op_q == MD_OP_DIV) ? div_hi : mult_hi;
                res_lo_q <= (op_q == MD_OP_DIV) ? div_lo : mult_lo;
            end
        end
    end

    assign hi_in = res_hi_q;
    assign lo_in = res_lo_q;

    logic unused_ok;
    assign unused_ok = wait_term;

endmodule
